spi_accel_target: RTL

//  SPI target (slave) emulating the ADXL345 register interface: the responder end of our 4-wire SPI master link.

---
 rtl/spi_accel_target.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_accel_target.sv
// ADXL345-style SPI mode-3 target: 64-entry register map, DEVID, coherent X/Y/Z snapshot, DATA_READY interrupt.
// Optional activity interrupt (oINT1, INT_SOURCE[4]) is built only when SPI_TGT_ACT_INT_EN is defined.
module spi_accel_target #(
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BW_RST      = 8'h0A
) (
  input  logic        iSPI_CLK,
  input  logic        iRSTN,
  input  logic        iSCLK,
  input  logic        iCSN,
  input  logic        iSDI,
  output logic        oSDO,
  output logic        oSDO_OE,
  input  logic [15:0] iDATA_X,
  input  logic [15:0] iDATA_Y,
  input  logic [15:0] iDATA_Z,
  input  logic        iSAMPLE_VLD,
  output logic        oMEASURE,
  output logic        oINT1,
  output logic        oINT2
);

  // Writable: 0x1D-0x2A, 0x2C-0x2F, 0x31, 0x38, 0x39
  localparam logic [63:0] WR_MASK = 64'h0302_F7FF_E000_0000;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, csn_sync_reg, sdi_sync_reg;
  logic sclk_d_reg, csn_d_reg;
  logic sclk_s, csn_s, sdi_s;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise, byte_done;

  logic [2:0]  bit_cnt_reg;
  logic [6:0]  rx_reg;
  logic [7:0]  rx_byte, tx_reg;
  logic [5:0]  addr_reg, addr_step, rd_addr;
  logic        mb_reg, sdo_reg;
  logic        wr_pend_reg;
  logic [5:0]  wr_addr_reg;
  logic [7:0]  wr_data_reg;
  logic [47:0] shadow_reg;
  logic        touch_data_reg, dr_reg, act_flag;
  logic [7:0]  rd_data;
  logic [7:0]  reg_q [64];

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sclk_sync_reg <= '1;
      csn_sync_reg  <= '1;
      sdi_sync_reg  <= '0;
      sclk_d_reg    <= 1'b1;
      csn_d_reg     <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], iSCLK};
      csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], iCSN};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], iSDI};
      sclk_d_reg    <= sclk_s;
      csn_d_reg     <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign csn_s     = csn_sync_reg[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg & ~csn_s;
  assign sclk_fall = ~sclk_s & sclk_d_reg & ~csn_s;
  assign csn_fall  = ~csn_s & csn_d_reg;
  assign csn_rise  = csn_s & ~csn_d_reg;
  assign rx_byte   = {rx_reg, sdi_s};
  assign byte_done = sclk_rise & (bit_cnt_reg == 3'd7);
  assign addr_step = mb_reg ? addr_reg + 6'd1 : addr_reg;

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (csn_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (csn_fall) state_next = CMD;
        CMD:     if (byte_done) state_next = rx_byte[7] ? RDATA : WDATA;
        default: state_next = state_reg;
      endcase
    end
  end

  // The byte being loaded comes from the fresh command address, or the stepped address mid-burst
  assign rd_addr = (state_reg == CMD) ? rx_byte[5:0] : addr_step;

  always_comb begin
    rd_data = reg_q[rd_addr];
    case (rd_addr)
      6'h00:   rd_data = DEVID_VAL;
      6'h30:   rd_data = {dr_reg, 2'b00, act_flag, 4'b0000};
      6'h32:   rd_data = shadow_reg[7:0];
      6'h33:   rd_data = shadow_reg[15:8];
      6'h34:   rd_data = shadow_reg[23:16];
      6'h35:   rd_data = shadow_reg[31:24];
      6'h36:   rd_data = shadow_reg[39:32];
      6'h37:   rd_data = shadow_reg[47:40];
      default: rd_data = reg_q[rd_addr];
    endcase
  end

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      bit_cnt_reg    <= '0;
      rx_reg         <= '0;
      tx_reg         <= '0;
      addr_reg       <= '0;
      mb_reg         <= 1'b0;
      sdo_reg        <= 1'b0;
      wr_pend_reg    <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      shadow_reg     <= '0;
      touch_data_reg <= 1'b0;
    end else begin
      wr_pend_reg <= 1'b0;
      if (csn_fall) begin
        bit_cnt_reg    <= '0;
        touch_data_reg <= 1'b0;
        shadow_reg     <= {iDATA_Z, iDATA_Y, iDATA_X};
      end else if (sclk_rise && state_reg != IDLE) begin
        rx_reg      <= rx_byte[6:0];
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          case (state_reg)
            CMD: begin
              addr_reg <= rx_byte[5:0];
              mb_reg   <= rx_byte[6];
              tx_reg   <= rd_data;
            end
            WDATA: begin
              wr_pend_reg <= 1'b1;
              wr_addr_reg <= addr_reg;
              wr_data_reg <= rx_byte;
              addr_reg    <= addr_step;
            end
            RDATA: begin
              if (addr_reg >= 6'h32 && addr_reg <= 6'h37) touch_data_reg <= 1'b1;
              addr_reg <= addr_step;
              tx_reg   <= rd_data;
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall && state_reg == RDATA) begin
        sdo_reg <= tx_reg[7];
        tx_reg  <= {tx_reg[6:0], 1'b0};
      end
      if (state_next != RDATA) sdo_reg <= 1'b0;
    end
  end

  // Only writable addresses ever change; everything else stays at its reset value of zero
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < 64; i++) reg_q[i] <= (i == 'h2C) ? BW_RST : 8'h00;
    end else if (wr_pend_reg && WR_MASK[wr_addr_reg]) begin
      reg_q[wr_addr_reg] <= wr_data_reg;
    end
  end

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN)                             dr_reg <= 1'b0;
    else if (iSAMPLE_VLD && oMEASURE)       dr_reg <= 1'b1;
    else if (csn_rise && touch_data_reg)    dr_reg <= 1'b0;
  end

`ifdef SPI_TGT_ACT_INT_EN
  logic [16:0] abs_x, abs_y, act_th;
  logic        act_reg, touch_src_reg, act_set;

  assign abs_x   = iDATA_X[15] ? 17'h0 - {1'b1, iDATA_X} : {1'b0, iDATA_X};
  assign abs_y   = iDATA_Y[15] ? 17'h0 - {1'b1, iDATA_Y} : {1'b0, iDATA_Y};
  assign act_th  = {5'b0, reg_q[6'h24], 4'b0000};
  assign act_set = iSAMPLE_VLD && ((reg_q[6'h27][6] && abs_x > act_th) ||
                                   (reg_q[6'h27][5] && abs_y > act_th));

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      act_reg       <= 1'b0;
      touch_src_reg <= 1'b0;
    end else begin
      if (csn_fall) touch_src_reg <= 1'b0;
      else if (byte_done && state_reg == RDATA && addr_reg == 6'h30) touch_src_reg <= 1'b1;
      if (act_set)                         act_reg <= 1'b1;
      else if (csn_rise && touch_src_reg)  act_reg <= 1'b0;
    end
  end
  assign act_flag = act_reg;
`else
  assign act_flag = 1'b0;
`endif

  assign oSDO     = sdo_reg;
  assign oSDO_OE  = (state_reg == RDATA);
  assign oMEASURE = reg_q[6'h2D][3];
  assign oINT1    = act_flag & reg_q[6'h2E][4] & ~reg_q[6'h2F][4];
  assign oINT2    = (dr_reg & reg_q[6'h2E][7] & reg_q[6'h2F][7]) |
                    (act_flag & reg_q[6'h2E][4] & reg_q[6'h2F][4]);

endmodule
